lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 142 ++++++++++++++
 tb/tb_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single-request FSM between the pipeline and a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module lsu #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_ctrl_r,
    output logic              dm_ctrl_w,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e      state_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        err_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] merge_c;
    logic [31:0] load_c;

    // Illegal size or address not aligned to the access size.
    always_comb begin
        err_c = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    // Lane extraction and merge, both working on the word read from dm in RD.
    always_comb begin
        byte_c  = dm_rdata[{off_q, 3'b000} +: 8];
        half_c  = dm_rdata[{off_q[1], 4'b0000} +: 16];
        merge_c = dm_rdata;
        load_c  = dm_rdata;
        case (size_q)
            2'b00: begin
                merge_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
                load_c = {{24{byte_c[7] & ~uns_q}}, byte_c};
            end
            2'b01: begin
                merge_c[{off_q[1], 4'b0000} +: 16] = wdata_q;
                load_c = {{16{half_c[15] & ~uns_q}}, half_c};
            end
            default: ;
        endcase
    end

    // The dm_wdata register doubles as the word buffer captured at the end of RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            dm_ctrl_r  <= 1'b0;
            dm_ctrl_w  <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= 32'h0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
        end else begin
            resp_valid <= 1'b0;
            dm_ctrl_r  <= 1'b0;
            dm_ctrl_w  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        size_q    <= req_size;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        dm_addr   <= {2'b00, req_addr[ADDR_W-1:2]};
                        req_ready <= 1'b0;
                        if (err_c) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_we && (req_size == 2'b10)) begin
                            state_q   <= WR;
                            dm_ctrl_w <= 1'b1;
                            dm_wdata  <= req_wdata;
                        end else begin
                            state_q   <= RD;
                            dm_ctrl_r <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        state_q   <= WR;
                        dm_ctrl_w <= 1'b1;
                        dm_wdata  <= merge_c;
                    end else begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_c;
                    end
                end
                WR: begin
                    state_q    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a 16-word dm model, directed scenarios and randomized traffic
// checked against a byte-lane arithmetic reference memory.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic        dm_ctrl_r;
    logic        dm_ctrl_w;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'h0;
    logic [31:0] pre_data = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dm_addr(dm_addr), .dm_ctrl_r(dm_ctrl_r),
        .dm_ctrl_w(dm_ctrl_w), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = dm_ctrl_r ? mem[dm_addr[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (dm_ctrl_w) mem[dm_addr[3:0]] <= dm_wdata;
    end

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a % 4);
            v = (w >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'((a / 2) % 2);
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (sz == 2'd2) return d;
        if (sz == 2'd0) begin
            sh = 8 * int'(a % 4);
            m = 32'hFF << sh;
        end else begin
            sh = 16 * int'((a / 2) % 2);
            m = 32'hFFFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 4'(idx); pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Drive one request and observe it through to its response pulse.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nr, output int nw,
                         output logic [31:0] rd, output logic er);
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nr = 0; nw = 0; rd = 32'hx; er = 1'bx;
        for (k = 1; k <= 10 && lat == 0; k++) begin
            nr += int'(dm_ctrl_r);
            nw += int'(dm_ctrl_w);
            if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; end
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        n_cmp++; if ({dm_ctrl_r, dm_ctrl_w} !== 2'b00) begin n_bad++; $display("FAIL reset_dm_ctrl got %b want 00", {dm_ctrl_r, dm_ctrl_w}); end
        n_cmp++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_dm_bus got %h/%h want 0/0", dm_addr, dm_wdata); end
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load;
        int lat, nr, nw; logic [31:0] rd; logic er;
        issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, lat, nr, nw, rd, er);
        ref_mem[2] = 32'hDEADBEEF;
        n_cmp++; if (mem[2] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_mem got %h want deadbeef", mem[2]); end
        n_cmp++; if (lat != 2 || nr != 0 || nw != 1) begin n_bad++; $display("FAIL sw_timing got lat%0d r%0d w%0d want lat2 r0 w1", lat, nr, nw); end
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL sw_resp got %h/%b want 0/0", rd, er); end
        issue(1'b0, 2'd2, 1'b1, 32'h08, 32'h0, lat, nr, nw, rd, er);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, er); end
        n_cmp++; if (lat != 2 || nr != 1 || nw != 0) begin n_bad++; $display("FAIL lw_timing got lat%0d r%0d w%0d want lat2 r1 w0", lat, nr, nw); end
    endtask

    task automatic test_byte_rmw;
        int lat, nr, nw; logic [31:0] rd; logic er;
        preload(2, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h09, 32'h555555AA, lat, nr, nw, rd, er);
        ref_mem[2] = 32'h1122AA44;
        n_cmp++; if (mem[2] !== 32'h1122AA44) begin n_bad++; $display("FAIL sb_rmw_mem got %h want 1122aa44", mem[2]); end
        n_cmp++; if (lat != 3 || nr != 1 || nw != 1) begin n_bad++; $display("FAIL sb_rmw_timing got lat%0d r%0d w%0d want lat3 r1 w1", lat, nr, nw); end
    endtask

    task automatic test_load_ext;
        logic [31:0] a [4] = '{32'h04, 32'h04, 32'h06, 32'h04};
        logic [1:0]  s [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        u [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'h0000FF80};
        int lat, nr, nw; logic [31:0] rd; logic er;
        preload(1, 32'h0080FF80);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, s[i], u[i], a[i], 32'h0, lat, nr, nw, rd, er);
            n_cmp++; if (rd !== e[i] || er !== 1'b0 || lat != 2) begin
                n_bad++; $display("FAIL load_ext%0d got %h/%b lat%0d want %h/0 lat2", i, rd, er, lat, e[i]);
            end
        end
    endtask

    task automatic test_misaligned;
        logic        w [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  s [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] a [3] = '{32'h02, 32'h05, 32'h00};
        int lat, nr, nw; logic [31:0] rd; logic er;
        for (int i = 0; i < 3; i++) begin
            issue(w[i], s[i], 1'b0, a[i], 32'hCAFEF00D, lat, nr, nw, rd, er);
            n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL misalign%0d_resp got %b/%h want 1/0", i, er, rd); end
            n_cmp++; if (lat != 1 || nr != 0 || nw != 0) begin n_bad++; $display("FAIL misalign%0d_timing got lat%0d r%0d w%0d want lat1 r0 w0", i, lat, nr, nw); end
        end
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (mem[j] !== ref_mem[j]) begin n_bad++; $display("FAIL misalign_mem%0d got %h want %h", j, mem[j], ref_mem[j]); end
        end
    endtask

    task automatic test_reset_mid;
        int seen_v, seen_w;
        preload(3, 32'h89ABCDEF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h0C; req_wdata = 32'h7E;
        @(posedge clk); #2;
        req_valid = 1'b0;
        n_cmp++; if (dm_ctrl_r !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_rd got %b want 1", dm_ctrl_r); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_resp got rdy%b v%b e%b d%h want 1 0 0 0", req_ready, resp_valid, resp_err, resp_rdata);
        end
        n_cmp++; if (dm_ctrl_r !== 1'b0 || dm_ctrl_w !== 1'b0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_dm got r%b w%b a%h d%h want 0 0 0 0", dm_ctrl_r, dm_ctrl_w, dm_addr, dm_wdata);
        end
        seen_v = 0; seen_w = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen_v += int'(resp_valid); seen_w += int'(dm_ctrl_w);
        end
        n_cmp++; if (seen_v != 0 || seen_w != 0) begin n_bad++; $display("FAIL rstmid_quiet got v%0d w%0d want 0 0", seen_v, seen_w); end
        n_cmp++; if (mem[3] !== 32'h89ABCDEF) begin n_bad++; $display("FAIL rstmid_mem got %h want 89abcdef", mem[3]); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d, rd2;
        int kr, ka, k2;
        d = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = d;
        @(posedge clk); #1;
        req_we = 1'b0; req_unsigned = 1'b0; req_wdata = ~d;
        kr = 0; ka = 0; k2 = 0; rd2 = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            if (resp_valid && kr == 0) kr = k;
            else if (resp_valid && ka != 0 && k2 == 0) begin k2 = k; rd2 = resp_rdata; end
            if (req_ready && kr != 0 && ka == 0) ka = k;
            else if (ka != 0 && k == ka + 1) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        ref_mem[0] = d;
        n_cmp++; if (kr != 2 || ka != kr + 1) begin n_bad++; $display("FAIL b2b_accept got resp%0d acc%0d want 2 3", kr, ka); end
        n_cmp++; if (k2 != 5) begin n_bad++; $display("FAIL b2b_second_resp got %0d want 5", k2); end
        n_cmp++; if (rd2 !== d || mem[0] !== d) begin n_bad++; $display("FAIL b2b_data got %h mem %h want %h", rd2, mem[0], d); end
    endtask

    task automatic test_random;
        int lat, nr, nw, elat, enr, enw;
        logic [31:0] rd, a, d, erd, hold;
        logic er, eer, we, uns;
        logic [1:0] sz;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom); uns = 1'($urandom); d = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
            eer = ref_err(sz, a);
            erd = 32'h0;
            if (eer) begin elat = 1; enr = 0; enw = 0; end
            else if (we) begin
                enr = (sz == 2'd2) ? 0 : 1; enw = 1; elat = 2 + enr;
                ref_mem[a / 4] = ref_store(ref_mem[a / 4], sz, a, d);
            end else begin
                elat = 2; enr = 1; enw = 0;
                erd = ref_load(ref_mem[a / 4], sz, uns, a);
            end
            issue(we, sz, uns, a, d, lat, nr, nw, rd, er);
            n_cmp++; if (rd !== erd || er !== eer) begin
                n_bad++; $display("FAIL rand%0d_resp we%b sz%0d a%h got %h/%b want %h/%b", i, we, sz, a, rd, er, erd, eer);
            end
            n_cmp++; if (lat != elat || nr != enr || nw != enw) begin
                n_bad++; $display("FAIL rand%0d_timing got lat%0d r%0d w%0d want lat%0d r%0d w%0d", i, lat, nr, nw, elat, enr, enw);
            end
            hold = resp_rdata;
            @(posedge clk); #1;
            n_cmp++; if (resp_valid !== 1'b0 || resp_rdata !== hold || resp_err !== er) begin
                n_bad++; $display("FAIL rand%0d_hold got v%b d%h e%b want 0 %h %b", i, resp_valid, resp_rdata, resp_err, hold, er);
            end
        end
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (mem[j] !== ref_mem[j]) begin n_bad++; $display("FAIL rand_mem%0d got %h want %h", j, mem[j], ref_mem[j]); end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_byte_rmw;
        test_load_ext;
        test_misaligned;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
